pixel_capture: RTL
==================

Name: pixel_capture

Overview:
- Receive-side endpoint of the pixel strobe link (write_en / sof / 4-bit data, one beat every second clock, 19200 beats per frame).
- Locks onto start-of-frame, writes each beat into a ping-pong frame buffer, and swaps banks at each completed frame.
- Flags framing errors (early or missing SOF) and resynchronises without corrupting the last good frame.
- Sits between the link input and the display/readout logic; the readout consumes rd_bank_o.

Parameters:
- PIXELS, 19200, beats per frame (160x120)
- PIX_W, 4, pixel width in bits
- ADDR_W, 15, frame-buffer address width per bank; must satisfy 2^ADDR_W >= PIXELS
- CNT_W, 16, width of the frame counter

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- write_en_i  in  1  beat strobe; data_i and sof_i are valid only when high
- sof_i  in  1  start of frame; qualified by write_en_i
- data_i  in  PIX_W  pixel data
- capture_en_i  in  1  enables capture; sampled only at frame boundaries
- fb_we_o  out  1  frame-buffer write enable
- fb_bank_o  out  1  bank being written
- fb_addr_o  out  ADDR_W  write address within the bank
- fb_data_o  out  PIX_W  write data
- rd_bank_o  out  1  bank holding the last complete frame
- frame_done_o  out  1  one-cycle pulse when a frame completes
- frame_err_o  out  1  one-cycle pulse on a framing error
- frame_cnt_o  out  CNT_W  completed frames, wraps
- err_cnt_o  out  8  framing errors, saturates at 255
- busy_o  out  1  high while in CAPTURE

Behaviour:
- Reset values: all outputs 0; rd_bank_o=0; fb_bank_o=1; state IDLE; pixel counter 0.
- Beat = write_en_i high. SOF beat = write_en_i && sof_i. Non-beat cycles are ignored, and data_i is don't-care on them.
- Write path: fb_we_o, fb_addr_o and fb_data_o are registered and appear exactly 1 cycle after the accepted beat. fb_we_o is low on every other cycle.
- IDLE:
  - SOF beat with capture_en_i=1: write addr 0, counter := 1, go to CAPTURE.
  - Any other beat is dropped.
- CAPTURE:
  - Non-SOF beat: write at addr = counter, then counter += 1.
  - If counter == PIXELS-1 at that beat (last pixel): frame_done_o pulses together with that write. Then rd_bank_o := fb_bank_o, fb_bank_o toggles, frame_cnt_o += 1, go to WAIT_SOF.
  - SOF beat while counter < PIXELS (early SOF): frame_err_o pulses and err_cnt_o increments. The beat restarts the frame at addr 0 in the same bank, counter := 1. No bank swap occurs.
- WAIT_SOF:
  - SOF beat with capture_en_i=1: write addr 0 into the new bank, counter := 1, go to CAPTURE (back-to-back frames with no gap).
  - SOF beat with capture_en_i=0: go to IDLE, no write.
  - Non-SOF beat (missing SOF): frame_err_o pulses, err_cnt_o increments, go to IDLE.
- capture_en_i deasserted mid-frame has no effect until the frame ends.
- rst_i mid-frame: immediate return to reset values. The partial frame is discarded and rd_bank_o returns to 0.
- Counters:
  - frame_cnt_o wraps from 2^CNT_W-1 to 0.
  - err_cnt_o holds at 255.
  - Addresses never exceed PIXELS-1.

Decomposition:
- Package pixel_link_pkg holds:
  - H_RES=160, V_RES=120, PIXELS, PIX_W, ADDR_W;
  - the cap_state_t enum {IDLE, CAPTURE, WAIT_SOF}.
- The transmit side shares the same package.
- One sub-module, pixel_capture_fsm, holds the state and pixel counter and emits the accept, last-pixel and error strobes. The top level holds the output registers, bank logic and counters.

Test Plan:
- Reset, then 2 clean frames (beats every 2nd clock, SOF on beat 0, data = addr[3:0]) -> 19200 writes per frame with addr 0..19199 and data matching. First frame is written to bank 1; frame_done_o pulses twice; rd_bank_o goes 1 then 0; frame_cnt_o=2; err_cnt_o=0.
- Beats before the first SOF, and with capture_en_i=0 -> no fb_we_o. Raise capture_en_i mid-frame -> capture starts at the next SOF only.
- SOF injected at beat 5000 -> frame_err_o pulses once, next write is addr 0 in the same bank, rd_bank_o unchanged, err_cnt_o=1.
- 19201st beat without SOF -> frame_err_o pulses, state goes to IDLE, the next SOF restarts capture, and the completed frame's bank remains in rd_bank_o.
- capture_en_i dropped at beat 10000 -> the frame finishes with done pulse and bank swap, the next SOF is ignored, busy_o=0.
- rst_i asserted at beat 7000 -> next cycle all outputs are at reset values; the following SOF starts a fresh capture at addr 0 in bank 1.

Source files
------------

// File: rtl/pixel_link_pkg.sv
// Shared definitions for the pixel strobe link (transmit and capture sides).
package pixel_link_pkg;

    localparam int H_RES  = 160;
    localparam int V_RES  = 120;
    localparam int PIXELS = H_RES * V_RES;
    localparam int PIX_W  = 4;
    localparam int ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        WAIT_SOF
    } cap_state_t;

endpackage

// File: rtl/pixel_capture_fsm.sv
// Frame-lock state machine: tracks position within the frame and flags
// accepted beats, the last pixel and framing errors.
module pixel_capture_fsm #(
    parameter int PIXELS = pixel_link_pkg::PIXELS,
    parameter int ADDR_W = pixel_link_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_en_i,
    input  logic              sof_i,
    input  logic              capture_en_i,
    output logic              accept_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              err_o,
    output logic              busy_o
);
    import pixel_link_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              sof_beat;
    logic              data_beat;

    assign sof_beat  = write_en_i & sof_i;
    assign data_beat = write_en_i & ~sof_i;
    assign busy_o    = (state_q == CAPTURE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // capture_en_i only matters where a new frame could begin
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        addr_o   = '0;
        last_o   = 1'b0;
        err_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sof_beat && capture_en_i) begin
                    accept_o = 1'b1;
                    cnt_d    = ADDR_W'(1);
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sof_beat) begin
                    // early SOF: restart the frame in the same bank
                    err_o    = 1'b1;
                    accept_o = 1'b1;
                    cnt_d    = ADDR_W'(1);
                end else if (data_beat) begin
                    accept_o = 1'b1;
                    addr_o   = cnt_q;
                    if (cnt_q == LAST_ADDR) begin
                        last_o  = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            WAIT_SOF: begin
                if (sof_beat) begin
                    if (capture_en_i) begin
                        accept_o = 1'b1;
                        cnt_d    = ADDR_W'(1);
                        state_d  = CAPTURE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (data_beat) begin
                    err_o   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/pixel_capture.sv
// Receive endpoint of the pixel strobe link: writes beats into a ping-pong
// frame buffer and hands each completed bank to the readout.
module pixel_capture #(
    parameter int PIXELS = pixel_link_pkg::PIXELS,
    parameter int PIX_W  = pixel_link_pkg::PIX_W,
    parameter int ADDR_W = pixel_link_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_en_i,
    input  logic              sof_i,
    input  logic [PIX_W-1:0]  data_i,
    input  logic              capture_en_i,
    output logic              fb_we_o,
    output logic              fb_bank_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [PIX_W-1:0]  fb_data_o,
    output logic              rd_bank_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [7:0]        err_cnt_o,
    output logic              busy_o
);
    import pixel_link_pkg::*;

    logic              accept;
    logic              last_pix;
    logic              frame_err;
    logic [ADDR_W-1:0] wr_addr;

    logic              fb_we_q, fb_we_d;
    logic              fb_bank_q, fb_bank_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]  fb_data_q, fb_data_d;
    logic              rd_bank_q, rd_bank_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    pixel_capture_fsm #(
        .PIXELS (PIXELS),
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .write_en_i   (write_en_i),
        .sof_i        (sof_i),
        .capture_en_i (capture_en_i),
        .accept_o     (accept),
        .addr_o       (wr_addr),
        .last_o       (last_pix),
        .err_o        (frame_err),
        .busy_o       (busy_o)
    );

    // The bank swap waits one cycle after the last write so that write is
    // still presented with the bank it belongs to.
    always_comb begin
        fb_we_d      = accept;
        fb_addr_d    = accept ? wr_addr : '0;
        fb_data_d    = accept ? data_i : '0;
        frame_done_d = last_pix;
        frame_err_d  = frame_err;
        fb_bank_d    = fb_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (frame_done_q) begin
            rd_bank_d   = fb_bank_q;
            fb_bank_d   = ~fb_bank_q;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fb_we_q      <= 1'b0;
            fb_bank_q    <= 1'b1;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            rd_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            fb_we_q      <= fb_we_d;
            fb_bank_q    <= fb_bank_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign fb_we_o      = fb_we_q;
    assign fb_bank_o    = fb_bank_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = fb_data_q;
    assign rd_bank_o    = rd_bank_q;
    assign frame_done_o = frame_done_q;
    assign frame_err_o  = frame_err_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
